pc_unit: RTL

Parametrised program-counter unit for the MIPS core: owns the PC register, selects the next fetch address (sequential, conditional branch, absolute jump, call, return, stop), and keeps a hardware return-address stack (RAS) so call/return pairs need no register-file round trip. It also supports a pipeline stall input and a sticky halt. It sits between the decoder/ALU branch result and the instruction fetch port. All addresses are word addresses; low byte-offset bits are never present.

---
 rtl/pc_pkg.sv | 16 +
 rtl/pc_unit_if.sv | 26 ++
 rtl/pc_ras.sv | 53 +++++
 rtl/pc_unit.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit and the decoder that drives it.
// Holds the 3-bit next-PC mode encoding.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_NORMAL   = 3'b000,
        PC_BRANCH   = 3'b001,
        PC_JUMP     = 3'b010,
        PC_STOP     = 3'b011,
        PC_CALL     = 3'b100,
        PC_RET      = 3'b101,
        PC_HOLD     = 3'b110,
        PC_HOLD_ALT = 3'b111
    } pc_inc_e;

endpackage

// File: rtl/pc_unit_if.sv
// Fetch-control bus between the decoder/ALU (master) and the PC unit (slave).
// There is no valid/ready pair: the command is consumed every falling edge unless stall is high.
interface pc_unit_if
    import pc_pkg::*;
#(
    parameter int ADDR_W = 32
);

    logic              stall;
    pc_inc_e           pc_inc;
    logic              alu_branch_result;
    logic [ADDR_W-1:0] abs_addr;
    logic [ADDR_W-1:0] branch_offset;
    logic [ADDR_W-1:0] current_pc;

    modport master (
        output stall, pc_inc, alu_branch_result, abs_addr, branch_offset,
        input  current_pc
    );

    modport slave (
        input  stall, pc_inc, alu_branch_result, abs_addr, branch_offset,
        output current_pc
    );

endinterface

// File: rtl/pc_ras.sv
// Return-address stack as a ring buffer; a push when full overwrites the oldest entry.
// State changes on the falling edge, matching the PC register.
module pc_ras
    import pc_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 8,
    localparam int PW = $clog2(RAS_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]     wp;
    logic [CW-1:0]     cnt;

    assign full  = (cnt == CW'(RAS_DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    // wp points at the next free slot, so the newest entry sits just below it.
    assign top   = mem[wp - PW'(1)];

    always_ff @(negedge clk) begin
        if (clr) begin
            wp  <= '0;
            cnt <= '0;
        end else if (push) begin
            wp <= wp + PW'(1);
            if (!full) begin
                cnt <= cnt + CW'(1);
            end
        end else if (pop && !empty) begin
            wp  <= wp - PW'(1);
            cnt <= cnt - CW'(1);
        end
    end

    always_ff @(negedge clk) begin
        if (push && !clr) begin
            mem[wp] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC mux, sticky halt, RAS status flags and optional counters.
// Define PC_PERF_EN to build the cycle/stall performance counters.
module pc_unit
    import pc_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter int          RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int CW = $clog2(RAS_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          clr,
    pc_unit_if.slave      bus,
    output logic          halted,
    output logic [CW-1:0] ras_count,
    output logic          ras_overflow,
    output logic          ras_underflow,
    output logic [31:0]   cycle_count,
    output logic [31:0]   stall_count
);

    logic [ADDR_W-1:0] pc_q;
    logic              halted_q;
    logic              ovf_q;
    logic              unf_q;

    logic [ADDR_W-1:0] seq;
    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] ras_top;
    logic              advance;
    logic              want_push;
    logic              want_pop;
    logic              set_halt;
    logic              set_ovf;
    logic              set_unf;
    logic              ras_full;
    logic              ras_empty;

    assign seq     = pc_q + ADDR_W'(1);
    assign tgt     = seq + bus.branch_offset;
    assign advance = !halted_q && !bus.stall;

    always_comb begin
        next_pc   = pc_q;
        want_push = 1'b0;
        want_pop  = 1'b0;
        set_halt  = 1'b0;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        case (bus.pc_inc)
            PC_NORMAL: next_pc = seq;
            PC_BRANCH: next_pc = bus.alu_branch_result ? tgt : seq;
            PC_JUMP:   next_pc = bus.abs_addr;
            PC_STOP:   set_halt = 1'b1;
            PC_CALL: begin
                next_pc   = bus.abs_addr;
                want_push = 1'b1;
                set_ovf   = ras_full;
            end
            PC_RET: begin
                // An empty stack falls through to the sequential address.
                if (ras_empty) begin
                    next_pc = seq;
                    set_unf = 1'b1;
                end else begin
                    next_pc  = ras_top;
                    want_pop = 1'b1;
                end
            end
            default: next_pc = pc_q;
        endcase
    end

    always_ff @(negedge clk) begin
        if (clr) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else if (advance) begin
            pc_q     <= next_pc;
            halted_q <= set_halt;
            ovf_q    <= ovf_q | set_ovf;
            unf_q    <= unf_q | set_unf;
        end
    end

    pc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .clr       (clr),
        .push      (want_push && advance),
        .pop       (want_pop && advance),
        .push_data (seq),
        .top       (ras_top),
        .full      (ras_full),
        .empty     (ras_empty),
        .count     (ras_count)
    );

    assign bus.current_pc = pc_q;
    assign halted         = halted_q;
    assign ras_overflow   = ovf_q;
    assign ras_underflow  = unf_q;

`ifdef PC_PERF_EN
    logic [31:0] cyc_q;
    logic [31:0] stl_q;

    always_ff @(negedge clk) begin
        if (clr) begin
            cyc_q <= '0;
            stl_q <= '0;
        end else if (!halted_q) begin
            if (bus.stall) begin
                stl_q <= stl_q + 32'd1;
            end else begin
                cyc_q <= cyc_q + 32'd1;
            end
        end
    end

    assign cycle_count = cyc_q;
    assign stall_count = stl_q;

`ifndef SYNTHESIS
    // Report the count including the STOP edge itself.
    always @(negedge clk) begin
        if (!clr && advance && bus.pc_inc == PC_STOP) begin
            $display("HALT, cycle_count: %0d", cyc_q + 32'd1);
        end
    end
`endif
`else
    assign cycle_count = '0;
    assign stall_count = '0;
`endif

endmodule
